// File: rtl/tick_enable_scheduler.sv
// rtl/tick_enable_scheduler.sv - three-channel programmable tick/enable generator
// IDLE/RUN/ALIGN sequencer with a single-slot divisor update port applied at period boundaries.
module tick_enable_scheduler #(
  parameter int          CNT_W    = 27,
  parameter int unsigned DEF_DIV0 = 100000,
  parameter int unsigned DEF_DIV1 = 1000000,
  parameter int unsigned DEF_DIV2 = 100000000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic [2:0]       tick,
  output logic [2:0]       sq_out,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALIGN = 2'd2
  } state_t;

  localparam logic [2:0][CNT_W-1:0] DEF_DIV = {
    CNT_W'(DEF_DIV2), CNT_W'(DEF_DIV1), CNT_W'(DEF_DIV0)
  };

  state_t                  cur;
  state_t                  nxt;
  logic [2:0][CNT_W-1:0]   cnt;
  logic [2:0][CNT_W-1:0]   div;
  logic [2:0][CNT_W-1:0]   cnt_nxt;
  logic [2:0][CNT_W-1:0]   div_nxt;
  logic [2:0]              term;
  logic [2:0]              sq_nxt;
  logic                    pend;
  logic [1:0]              pend_ch;
  logic [CNT_W-1:0]        pend_div;
  logic                    apply;
  logic                    accept;
  logic                    bad;

  // stop outranks sync, sync outranks start
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE: begin
        if (cmd_stop)       nxt = IDLE;
        else if (cmd_start) nxt = RUN;
      end
      RUN: begin
        if (cmd_stop)       nxt = IDLE;
        else if (cmd_sync)  nxt = ALIGN;
      end
      ALIGN: begin
        if (cmd_stop)       nxt = IDLE;
        else                nxt = RUN;
      end
      default:              nxt = IDLE;
    endcase
  end

  // Outside RUN (and on leaving it) a pending divisor lands at once; inside RUN only at its channel's wrap.
  always_comb begin
    apply   = 1'b0;
    term    = '0;
    cnt_nxt = cnt;
    div_nxt = div;
    sq_nxt  = '1;
    for (int i = 0; i < 3; i++) begin
      term[i] = (cur == RUN) && (cnt[i] == div[i] - CNT_W'(1));
      if (pend && (pend_ch == 2'(i)) && ((cur != RUN) || (nxt != RUN) || term[i])) begin
        div_nxt[i] = pend_div;
        apply      = 1'b1;
      end
      cnt_nxt[i] = ((cur == RUN) && (nxt == RUN) && !term[i]) ? cnt[i] + CNT_W'(1) : '0;
      sq_nxt[i]  = (nxt != RUN) || (cnt_nxt[i] < div_nxt[i] - (div_nxt[i] >> 1));
    end
  end

  assign accept    = cfg_valid && !pend;
  assign bad       = (cfg_ch == 2'd3) || (cfg_div < CNT_W'(2));
  assign cfg_ready = !pend;
  assign tick      = term;
  assign state     = cur;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cur      <= IDLE;
      cnt      <= '0;
      div      <= DEF_DIV;
      sq_out   <= '1;
      cfg_err  <= 1'b0;
      pend     <= 1'b0;
      pend_ch  <= '0;
      pend_div <= '0;
    end else begin
      cur     <= nxt;
      cnt     <= cnt_nxt;
      div     <= div_nxt;
      sq_out  <= sq_nxt;
      cfg_err <= accept && bad;
      if (apply) begin
        pend <= 1'b0;
      end else if (accept && !bad) begin
        pend     <= 1'b1;
        pend_ch  <= cfg_ch;
        pend_div <= cfg_div;
      end
    end
  end

endmodule
